// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of fetched words plus
// branch-prediction metadata, presented oldest-first to the decoder.
module fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [31:0]             i_instr,
  input  logic [ADDR_WIDTH-1:0]   i_pc,
  input  logic                    i_guesses_branch,
  input  logic [ADDR_WIDTH-1:0]   i_prediction,
  input  logic                    i_flush,
  output logic                    o_valid,
  input  logic                    i_dec_ready,
  output logic [31:0]             o_instr,
  output logic [ADDR_WIDTH-1:0]   o_pc,
  output logic                    o_guesses_branch,
  output logic [ADDR_WIDTH-1:0]   o_prediction,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  guess;
    logic [ADDR_WIDTH-1:0] pred;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head_e;
  entry_t        out_e;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;

  assign o_ready = (count_q != CW'(DEPTH));
  assign o_valid = (count_q != '0);

  // A flush swallows any handshake in the same cycle.
  assign push = i_valid & o_ready & ~i_flush;
  assign pop  = o_valid & i_dec_ready & ~i_flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    unique case (1'b1)
      i_flush: begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
      push & ~pop: count_d = count_q + CW'(1);
      pop & ~push: count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= '{
        instr: i_instr,
        pc:    i_pc,
        guess: i_guesses_branch,
        pred:  i_prediction
      };
    end
  end

  assign head_e = mem_q[head_q];
  // Empty head reads as opcode 0 so decode sees an invalid/NOP word.
  assign out_e  = o_valid ? head_e : '0;

  assign o_instr          = out_e.instr;
  assign o_pc             = out_e.pc;
  assign o_guesses_branch = out_e.guess;
  assign o_prediction     = out_e.pred;
  assign o_count          = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed plan plus random traffic
// checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  typedef struct {
    logic [31:0]   instr;
    logic [AW-1:0] pc;
    logic          guess;
    logic [AW-1:0] pred;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [31:0]   i_instr;
  logic [AW-1:0] i_pc;
  logic          i_guesses_branch;
  logic [AW-1:0] i_prediction;
  logic          i_flush;
  logic          o_valid;
  logic          i_dec_ready;
  logic [31:0]   o_instr;
  logic [AW-1:0] o_pc;
  logic          o_guesses_branch;
  logic [AW-1:0] o_prediction;
  logic [2:0]    o_count;

  int n_tests = 0;
  int n_fail  = 0;
  ent_t mq[$];

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .i_instr          (i_instr),
    .i_pc             (i_pc),
    .i_guesses_branch (i_guesses_branch),
    .i_prediction     (i_prediction),
    .i_flush          (i_flush),
    .o_valid          (o_valid),
    .i_dec_ready      (i_dec_ready),
    .o_instr          (o_instr),
    .o_pc             (o_pc),
    .o_guesses_branch (o_guesses_branch),
    .o_prediction     (o_prediction),
    .o_count          (o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    ent_t e;
    e = '{instr: '0, pc: '0, guess: 1'b0, pred: '0};
    if (mq.size() > 0) e = mq[0];
    chk({tag, ".valid"}, 64'(o_valid), 64'(mq.size() > 0));
    chk({tag, ".ready"}, 64'(o_ready), 64'(mq.size() < DEPTH));
    chk({tag, ".count"}, 64'(o_count), 64'(mq.size()));
    chk({tag, ".instr"}, 64'(o_instr), 64'(e.instr));
    chk({tag, ".pc"},    64'(o_pc),    64'(e.pc));
    chk({tag, ".guess"}, 64'(o_guesses_branch), 64'(e.guess));
    chk({tag, ".pred"},  64'(o_prediction), 64'(e.pred));
  endtask

  // Model reflects the queue as seen before the edge.
  task automatic step(input string tag,
                      input logic v, input logic [AW-1:0] pc,
                      input logic dr, input logic fl);
    bit   do_push, do_pop;
    ent_t e;
    i_valid          = v;
    i_pc             = pc;
    i_instr          = pc ^ 32'h00500093;
    i_guesses_branch = pc[2];
    i_prediction     = pc + 4;
    i_dec_ready      = dr;
    i_flush          = fl;
    e = '{instr: i_instr, pc: i_pc,
          guess: i_guesses_branch, pred: i_prediction};
    do_push = v && (mq.size() < DEPTH) && !fl;
    do_pop  = dr && (mq.size() > 0) && !fl;
    @(posedge clk);
    if (fl) mq.delete();
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(e);
    #1;
    chk_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 0; i_instr = 0; i_pc = 0;
    i_guesses_branch = 0; i_prediction = 0;
    i_flush = 0; i_dec_ready = 0;
    #12;
    chk_all("reset");
    rst_n = 1'b1;
    step("idle", 0, 0, 1, 0);

    // Single push with exact plan values.
    i_valid = 1; i_pc = 32'h100; i_instr = 32'h00500093;
    i_guesses_branch = 0; i_prediction = 32'h104;
    i_dec_ready = 0; i_flush = 0;
    @(posedge clk); #1;
    i_valid = 0;
    chk("one.instr", 64'(o_instr), 64'h00500093);
    chk("one.pc",    64'(o_pc),    64'h100);
    chk("one.pred",  64'(o_prediction), 64'h104);
    chk("one.count", 64'(o_count), 64'd1);
    mq.push_back('{instr: 32'h00500093, pc: 32'h100,
                   guess: 1'b0, pred: 32'h104});
    step("one.pop", 0, 0, 1, 0);

    // Fill, overfill attempt, drain.
    for (int k = 0; k < 4; k++) step("fill", 1, 32'h100 + 4*k, 0, 0);
    step("full.push", 1, 32'h110, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("drain.pc", 64'(o_pc), 64'(32'h100 + 4*k));
      step("drain", 0, 0, 1, 0);
    end

    // Streaming with wrap.
    for (int k = 0; k < 10; k++) step("stream", 1, 32'h200 + 4*k, 1, 0);
    step("stream.end", 0, 0, 1, 0);

    // Flush with concurrent push and pop.
    for (int k = 0; k < 3; k++) step("pre.fl", 1, 32'h280 + 4*k, 0, 0);
    step("flush", 1, 32'h300, 1, 1);
    chk("flush.count", 64'(o_count), 64'd0);
    step("post.fl", 1, 32'h400, 0, 0);
    chk("post.fl.pc", 64'(o_pc), 64'h400);
    step("clr", 0, 0, 1, 0);

    // Full then pop, then push refills.
    for (int k = 0; k < 4; k++) step("refill", 1, 32'h600 + 4*k, 0, 0);
    step("full.pop", 0, 0, 1, 0);
    chk("full.pop.rdy", 64'(o_ready), 64'd1);
    step("full.push2", 1, 32'h700, 0, 0);
    chk("full.cnt4", 64'(o_count), 64'd4);
    step("flush2", 0, 0, 0, 1);

    // Asynchronous reset mid-stream.
    step("ar.a", 1, 32'h800, 0, 0);
    step("ar.b", 1, 32'h804, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    chk("ar.valid", 64'(o_valid), 64'd0);
    chk("ar.count", 64'(o_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("ar.push", 1, 32'h500, 0, 0);
    chk("ar.pc", 64'(o_pc), 64'h500);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step("rand",
           1'($urandom_range(0, 3) != 0),
           $urandom & 32'hFFFF_FFFC,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
